// File: rtl/spi_master_if.sv
// Host- and slave-facing signals of the byte-wide SPI master, bundled for port connection.
interface spi_master_if;
  logic       start;
  logic [7:0] data_in;
  logic       buzy;
  logic       done;
  logic [7:0] data_out;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       sclk;

  modport master (
    input  start, data_in, miso,
    output buzy, done, data_out, cs, mosi, sclk
  );

  modport slave (
    output start, data_in, miso,
    input  buzy, done, data_out, cs, mosi, sclk
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide full-duplex SPI master, mode 0, MSB first; sclk half-period is CLK_DIV clk cycles.
module spi_master #(
  parameter int unsigned CLK_DIV = 1
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int unsigned      DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e          r_state, w_state_next;
  logic [7:0]      r_tx_sh, w_tx_sh;
  // Only seven bits are kept: the eighth received bit goes straight into data_out.
  logic [6:0]      r_rx_sh, w_rx_sh;
  logic [2:0]      r_bit_cnt, w_bit_cnt;
  logic [DivW-1:0] r_div_cnt, w_div_cnt;
  logic            r_cs, w_cs;
  logic            r_sclk, w_sclk;
  logic            r_buzy, w_buzy;
  logic            r_done, w_done;
  logic [7:0]      r_data_out, w_data_out;

  logic w_tick, w_fall, w_last;

  assign w_tick = (r_state == StXfer) && (r_div_cnt == DivMax);
  assign w_fall = w_tick && r_sclk;
  assign w_last = w_fall && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_tx_sh    <= 8'h00;
      r_rx_sh    <= 7'h00;
      r_bit_cnt  <= 3'd0;
      r_div_cnt  <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_buzy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_tx_sh    <= w_tx_sh;
      r_rx_sh    <= w_rx_sh;
      r_bit_cnt  <= w_bit_cnt;
      r_div_cnt  <= w_div_cnt;
      r_cs       <= w_cs;
      r_sclk     <= w_sclk;
      r_buzy     <= w_buzy;
      r_done     <= w_done;
      r_data_out <= w_data_out;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StXfer;
      StXfer:  if (w_last)    w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_tx_sh    = r_tx_sh;
    w_rx_sh    = r_rx_sh;
    w_bit_cnt  = r_bit_cnt;
    w_div_cnt  = r_div_cnt;
    w_cs       = r_cs;
    w_sclk     = r_sclk;
    w_buzy     = r_buzy;
    w_done     = 1'b0;
    w_data_out = r_data_out;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_tx_sh   = bus.data_in;
          w_cs      = 1'b0;
          w_buzy    = 1'b1;
          w_sclk    = 1'b0;
          w_bit_cnt = 3'd0;
          w_div_cnt = '0;
        end
      end
      StXfer: begin
        if (w_tick) begin
          w_div_cnt = '0;
          w_sclk    = ~r_sclk;
          if (w_fall) begin
            w_rx_sh = {r_rx_sh[5:0], bus.miso};
            if (w_last) begin
              w_data_out = {r_rx_sh, bus.miso};
              w_done     = 1'b1;
              w_buzy     = 1'b0;
              w_cs       = 1'b1;
              w_tx_sh    = 8'h00;
            end else begin
              w_bit_cnt = r_bit_cnt + 3'd1;
              w_tx_sh   = {r_tx_sh[6:0], 1'b0};
            end
          end
        end else begin
          w_div_cnt = r_div_cnt + DivW'(1);
        end
      end
      default: ;
    endcase
  end

  // mosi is the head of the transmit register, which is cleared when idle.
  assign bus.mosi     = r_tx_sh[7];
  assign bus.cs       = r_cs;
  assign bus.sclk     = r_sclk;
  assign bus.buzy     = r_buzy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: CLK_DIV=1 and CLK_DIV=2 instances, slave model on miso.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_if if1 ();
  spi_master_if if2 ();

  spi_master #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  spi_master #(.CLK_DIV(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  int errors = 0;
  int checks = 0;

  // Slave model: presents byte MSB first, advancing one bit per sclk fall while selected.
  logic [7:0] sl_byte1 = 8'h00, sl_byte2 = 8'h00;
  bit         loop1 = 1'b0;
  int         idx1 = 0, idx2 = 0;

  always @(posedge if1.cs or negedge if1.sclk) begin
    if (if1.cs) idx1 = 0;
    else        idx1 = idx1 + 1;
  end
  always @(posedge if2.cs or negedge if2.sclk) begin
    if (if2.cs) idx2 = 0;
    else        idx2 = idx2 + 1;
  end

  always_comb begin
    if1.miso = 1'b0;
    if (loop1)        if1.miso = if1.mosi;
    else if (idx1 < 8) if1.miso = sl_byte1[3'(7 - idx1)];
  end
  always_comb begin
    if2.miso = 1'b0;
    if (idx2 < 8) if2.miso = sl_byte2[3'(7 - idx2)];
  end

  // Observation mux so one transfer task serves both instances.
  bit         dsel = 1'b0;
  logic       o_cs, o_sclk, o_mosi, o_buzy, o_done;
  logic [7:0] o_data_out;
  always_comb begin
    o_cs       = dsel ? if2.cs       : if1.cs;
    o_sclk     = dsel ? if2.sclk     : if1.sclk;
    o_mosi     = dsel ? if2.mosi     : if1.mosi;
    o_buzy     = dsel ? if2.buzy     : if1.buzy;
    o_done     = dsel ? if2.done     : if1.done;
    o_data_out = dsel ? if2.data_out : if1.data_out;
  end

  logic [7:0] last_out1 = 8'h00, last_out2 = 8'h00;

  task automatic check(input string tag, input string name, input int k,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s cycle=%0d got=%0h expected=%0h", tag, name, k, act, exp);
    end
  endtask

  task automatic drive_start(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin
      if2.start   = s;
      if2.data_in = d;
    end else begin
      if1.start   = s;
      if1.data_in = d;
    end
  endtask

  // One transfer; every expectation derives from tx, exp_out and the sclk period 2*d.
  task automatic run_xfer(input bit sel, input logic [7:0] tx, input logic [7:0] sl,
                          input bit lp, input bit glitch, input logic [7:0] exp_out,
                          input string tag);
    int         d;
    int         n;
    logic [7:0] t;
    logic [7:0] prev;
    d    = sel ? 2 : 1;
    n    = 16 * d;
    t    = tx;
    prev = sel ? last_out2 : last_out1;
    if (sel) sl_byte2 = sl;
    else begin
      sl_byte1 = sl;
      loop1    = lp;
    end
    dsel = sel;
    @(negedge clk);
    drive_start(sel, 1'b1, tx);
    @(posedge clk);
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 0) drive_start(sel, 1'b0, tx);
      if (glitch && k == 4) drive_start(sel, 1'b1, 8'hFF);
      if (glitch && k == 5) drive_start(sel, 1'b0, 8'hFF);
      if (k < n) begin
        check(tag, "cs", k, {7'd0, o_cs}, 8'd0);
        check(tag, "buzy", k, {7'd0, o_buzy}, 8'd1);
        check(tag, "done", k, {7'd0, o_done}, 8'd0);
        check(tag, "sclk", k, {7'd0, o_sclk}, 8'((k / d) % 2));
        check(tag, "mosi", k, {7'd0, o_mosi}, {7'd0, t[3'(7 - k / (2 * d))]});
        check(tag, "data_out_hold", k, o_data_out, prev);
      end else if (k == n) begin
        check(tag, "cs", k, {7'd0, o_cs}, 8'd1);
        check(tag, "buzy", k, {7'd0, o_buzy}, 8'd0);
        check(tag, "done", k, {7'd0, o_done}, 8'd1);
        check(tag, "sclk", k, {7'd0, o_sclk}, 8'd0);
        check(tag, "mosi", k, {7'd0, o_mosi}, 8'd0);
        check(tag, "data_out", k, o_data_out, exp_out);
      end else begin
        check(tag, "done_clear", k, {7'd0, o_done}, 8'd0);
        check(tag, "cs_idle", k, {7'd0, o_cs}, 8'd1);
        check(tag, "data_out", k, o_data_out, exp_out);
      end
    end
    if (sel) last_out2 = exp_out;
    else     last_out1 = exp_out;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sl;
    bit         lp;
    bit         gl;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] rtx, rsl;
    bit         rsel;
    bit         exp_done;

    vecs[0] = '{tx: 8'hA5, sl: 8'h00, lp: 1'b1, gl: 1'b0, exp_out: 8'hA5};
    vecs[1] = '{tx: 8'h00, sl: 8'hFF, lp: 1'b0, gl: 1'b0, exp_out: 8'hFF};
    vecs[2] = '{tx: 8'hC3, sl: 8'h5A, lp: 1'b0, gl: 1'b1, exp_out: 8'h5A};
    vecs[3] = '{tx: 8'h01, sl: 8'h80, lp: 1'b0, gl: 1'b0, exp_out: 8'h80};
    vecs[4] = '{tx: 8'hFF, sl: 8'h00, lp: 1'b1, gl: 1'b0, exp_out: 8'hFF};

    reset = 1'b0;
    drive_start(1'b0, 1'b0, 8'h00);
    drive_start(1'b1, 1'b0, 8'h00);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", "cs1", 0, {7'd0, if1.cs}, 8'd1);
    check("reset", "sclk1", 0, {7'd0, if1.sclk}, 8'd0);
    check("reset", "mosi1", 0, {7'd0, if1.mosi}, 8'd0);
    check("reset", "buzy1", 0, {7'd0, if1.buzy}, 8'd0);
    check("reset", "done1", 0, {7'd0, if1.done}, 8'd0);
    check("reset", "data_out1", 0, if1.data_out, 8'h00);
    check("reset", "cs2", 0, {7'd0, if2.cs}, 8'd1);
    check("reset", "data_out2", 0, if2.data_out, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_xfer(1'b0, vecs[i].tx, vecs[i].sl, vecs[i].lp, vecs[i].gl, vecs[i].exp_out, "vec");

    run_xfer(1'b1, 8'h69, 8'h3C, 1'b0, 1'b0, 8'h3C, "div2");

    for (int i = 0; i < 8; i++) begin
      rsel = 1'(i % 2);
      rtx  = 8'($urandom);
      rsl  = 8'($urandom);
      run_xfer(rsel, rtx, rsl, 1'b0, 1'b0, rsl, "rand");
    end

    // Back-to-back: start held high, done expected at E0+16, +33, +50.
    dsel     = 1'b0;
    loop1    = 1'b0;
    sl_byte1 = 8'h96;
    @(negedge clk);
    drive_start(1'b0, 1'b1, 8'h5B);
    @(posedge clk);
    for (int c = 0; c <= 55; c++) begin
      @(negedge clk);
      if (c == 40) drive_start(1'b0, 1'b0, 8'h5B);
      exp_done = (c == 16) || (c == 33) || (c == 50);
      check("b2b", "done", c, {7'd0, o_done}, {7'd0, exp_done});
      if (exp_done) begin
        check("b2b", "cs_gap", c, {7'd0, o_cs}, 8'd1);
        check("b2b", "data_out", c, o_data_out, 8'h96);
      end
      if (c == 17 || c == 34) check("b2b", "cs_restart", c, {7'd0, o_cs}, 8'd0);
    end
    last_out1 = 8'h96;

    // Abort with an asynchronous reset at E0+7.
    sl_byte1 = 8'h3F;
    @(negedge clk);
    drive_start(1'b0, 1'b1, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 8'hA5);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort", "cs", 7, {7'd0, if1.cs}, 8'd1);
    check("abort", "sclk", 7, {7'd0, if1.sclk}, 8'd0);
    check("abort", "buzy", 7, {7'd0, if1.buzy}, 8'd0);
    check("abort", "mosi", 7, {7'd0, if1.mosi}, 8'd0);
    check("abort", "data_out", 7, if1.data_out, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort", "done", c, {7'd0, if1.done}, 8'd0);
    end
    reset     = 1'b0;
    last_out1 = 8'h00;
    last_out2 = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 19) check("abort", "no_done", c, {7'd0, if1.done}, 8'd0);
    end
    run_xfer(1'b0, 8'h3C, 8'hC7, 1'b0, 1'b0, 8'hC7, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
